reorder_buffer: RTL

//  In-order retirement queue for the R10K pipeline. Dispatch allocates one entry per

---
 rtl/reorder_buffer.sv | 103 ++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement queue: dispatch allocates at the tail, CDB broadcasts mark
// entries complete, the completed head retires, and mispredicts squash younger entries.
module reorder_buffer #(
    parameter int ROB_SIZE = 32,
    parameter int PR_W     = 6,
    parameter int AR_W     = 5,
    parameter int IDX_W    = $clog2(ROB_SIZE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dispatch_en,
    input  logic [PR_W-1:0]  dispatch_T_new,
    input  logic [PR_W-1:0]  dispatch_T_old,
    input  logic [AR_W-1:0]  dispatch_arch_reg,
    input  logic             cdb_valid,
    input  logic [PR_W-1:0]  cdb_tag,
    input  logic             branch_incorrect,
    input  logic [IDX_W-1:0] branch_rob_idx,
    output logic [IDX_W-1:0] dispatch_idx,
    output logic [IDX_W:0]   num_entries,
    output logic             full,
    output logic             empty,
    output logic             retire_en,
    output logic [PR_W-1:0]  retire_T_old,
    output logic [PR_W-1:0]  retire_T_new,
    output logic [AR_W-1:0]  retire_arch_reg
);

    logic [IDX_W:0]      head_q, head_d, tail_q, tail_d;
    logic [ROB_SIZE-1:0] valid_q, valid_d, complete_q, complete_d;
    logic [ROB_SIZE-1:0] younger, cdb_hit;
    logic [PR_W-1:0]     t_new_q [ROB_SIZE];
    logic [PR_W-1:0]     t_old_q [ROB_SIZE];
    logic [AR_W-1:0]     arch_q  [ROB_SIZE];
    logic [IDX_W-1:0]    head_idx, tail_idx, branch_off;
    logic                dispatch_fire;

    assign head_idx     = head_q[IDX_W-1:0];
    assign tail_idx     = tail_q[IDX_W-1:0];
    assign num_entries  = tail_q - head_q;
    assign full         = (num_entries == (IDX_W+1)'(ROB_SIZE));
    assign empty        = (num_entries == '0);
    assign dispatch_idx = tail_idx;

    assign retire_en       = !empty && complete_q[head_idx];
    assign retire_T_old    = retire_en ? t_old_q[head_idx] : '0;
    assign retire_T_new    = retire_en ? t_new_q[head_idx] : '0;
    assign retire_arch_reg = retire_en ? arch_q[head_idx]  : '0;

    // Handshake: dispatch_en is a valid with an implicit ready of !full; a beat is
    // accepted only when both hold and no mispredict recovery happens in that cycle.
    assign dispatch_fire = dispatch_en && !full && !branch_incorrect;
    assign branch_off    = branch_rob_idx - head_idx;

    // Age of slot i is its distance from head; anything older-than-branch survives.
    for (genvar i = 0; i < ROB_SIZE; i++) begin : g_slot
        assign younger[i] = branch_incorrect && ((IDX_W'(i) - head_idx) > branch_off);
        assign cdb_hit[i] = cdb_valid && valid_q[i] && (t_new_q[i] == cdb_tag);
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        valid_d    = valid_q & ~younger;
        complete_d = (complete_q | cdb_hit) & ~younger;
        if (retire_en) begin
            head_d               = head_q + (IDX_W+1)'(1);
            valid_d[head_idx]    = 1'b0;
            complete_d[head_idx] = 1'b0;
        end
        if (branch_incorrect) begin
            tail_d = head_q + (IDX_W+1)'(branch_off) + (IDX_W+1)'(1);
        end else if (dispatch_fire) begin
            tail_d               = tail_q + (IDX_W+1)'(1);
            valid_d[tail_idx]    = 1'b1;
            complete_d[tail_idx] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            valid_q    <= '0;
            complete_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= valid_d;
            complete_q <= complete_d;
        end
    end

    // Payload carries no reset: outputs are gated by retire_en, which needs complete.
    always_ff @(posedge clock) begin
        if (!reset && dispatch_fire) begin
            t_new_q[tail_idx] <= dispatch_T_new;
            t_old_q[tail_idx] <= dispatch_T_old;
            arch_q[tail_idx]  <= dispatch_arch_reg;
        end
    end

endmodule
